// File: rtl/skel_sched_pkg.sv
// Shared types and constants for the skeleton frame scheduler.
//   sched_state_t  : scheduler state encoding (also driven on state_out)
//   RECOVER_CYCLES : length of the skeletonizer reset pulse in clk_in cycles
package skel_sched_pkg;

    typedef enum logic [2:0] {
        ST_RECOVER = 3'd0,
        ST_IDLE    = 3'd1,
        ST_ARM     = 3'd2,
        ST_LOAD    = 3'd3,
        ST_PROCESS = 3'd4
    } sched_state_t;

    localparam int RECOVER_CYCLES = 4;

endpackage

// File: rtl/skeleton_frame_scheduler_sat_counter.sv
// Saturating event counter used for the debug HUD statistics.
//   clk_in    : system clock
//   rst_in    : asynchronous active-high reset, clears the count
//   inc_in    : count one event this cycle
//   count_out : current count, holds at all-ones once reached
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             inc_in,
    output logic [WIDTH-1:0] count_out
);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            count_out <= '0;
        end else if (inc_in && (count_out != '1)) begin
            count_out <= count_out + 1'b1;
        end
    end

endmodule

// File: rtl/skeleton_frame_scheduler.sv
// Admits one complete camera frame at a time into the skeletonizer, drops
// frames that arrive while a skeleton is being computed, detects completion
// from the skeletonizer output stream and resets a hung skeletonizer.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// RECOVER(0) | skel_rst_out held high for RECOVER_CYCLES cycles
// IDLE   (1) | not admitting, nothing forwarded
// ARM    (2) | waiting for start-of-frame
// LOAD   (3) | forwarding the admitted frame up to end-of-frame
// PROCESS(4) | skeletonizer busy; watchdog running, new frames dropped
//
// Ports:
//   clk_in, rst_in                     : clock, async active-high reset
//   enable_in                          : admit new frames when high
//   hcount_in/vcount_in/pixel_in/
//   pixel_valid_in                     : thresholded camera stream
//   skel_valid_in/skel_hcount_in/
//   skel_vcount_in                     : skeletonizer output stream
//   skel_hcount_out/skel_vcount_out/
//   skel_pixel_out/skel_valid_out      : registered stream to skeletonizer
//   skel_rst_out                       : reset to skeletonizer
//   frame_done_out                     : one-cycle pulse per finished skeleton
//   frames_done_out/frames_dropped_out/
//   timeouts_out                       : saturating statistics
//   state_out                          : current state encoding
module skeleton_frame_scheduler
    import skel_sched_pkg::*;
#(
    parameter int HORIZONTAL_COUNT = 320,
    parameter int VERTICAL_COUNT   = 180,
    parameter int TIMEOUT_CYCLES   = 2_000_000,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                                clk_in,
    input  logic                                rst_in,
    input  logic                                enable_in,
    input  logic [$clog2(HORIZONTAL_COUNT)-1:0] hcount_in,
    input  logic [$clog2(VERTICAL_COUNT)-1:0]   vcount_in,
    input  logic                                pixel_in,
    input  logic                                pixel_valid_in,
    input  logic                                skel_valid_in,
    input  logic [$clog2(HORIZONTAL_COUNT)-1:0] skel_hcount_in,
    input  logic [$clog2(VERTICAL_COUNT)-1:0]   skel_vcount_in,
    output logic [$clog2(HORIZONTAL_COUNT)-1:0] skel_hcount_out,
    output logic [$clog2(VERTICAL_COUNT)-1:0]   skel_vcount_out,
    output logic                                skel_pixel_out,
    output logic                                skel_valid_out,
    output logic                                skel_rst_out,
    output logic                                frame_done_out,
    output logic [CNT_WIDTH-1:0]                frames_done_out,
    output logic [CNT_WIDTH-1:0]                frames_dropped_out,
    output logic [CNT_WIDTH-1:0]                timeouts_out,
    output logic [2:0]                          state_out
);

    localparam int HWIDTH = $clog2(HORIZONTAL_COUNT);
    localparam int VWIDTH = $clog2(VERTICAL_COUNT);
    localparam int REC_W  = $clog2(RECOVER_CYCLES);
    localparam int WD_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [HWIDTH-1:0] H_LAST    = HWIDTH'(HORIZONTAL_COUNT - 1);
    localparam logic [VWIDTH-1:0] V_LAST    = VWIDTH'(VERTICAL_COUNT - 1);
    localparam logic [REC_W-1:0]  REC_LAST  = REC_W'(RECOVER_CYCLES - 1);
    localparam logic [WD_W-1:0]   WD_RELOAD = WD_W'(TIMEOUT_CYCLES - 1);

    sched_state_t      state, state_d;
    logic [REC_W-1:0]  rec_cnt, rec_d;
    // Watchdog is a down-counter: reload on entry to PROCESS, fire at zero,
    // which lands on the TIMEOUT_CYCLES-th PROCESS cycle.
    logic [WD_W-1:0]   wd_cnt, wd_d;
    logic              fwd, inc_done, inc_drop, inc_to;
    logic              sof, eof, skel_last;

    assign sof       = pixel_valid_in && (hcount_in == '0) && (vcount_in == '0);
    assign eof       = pixel_valid_in && (hcount_in == H_LAST) && (vcount_in == V_LAST);
    assign skel_last = skel_valid_in && (skel_hcount_in == H_LAST) &&
                       (skel_vcount_in == V_LAST);

    always_comb begin
        state_d  = state;
        rec_d    = rec_cnt;
        wd_d     = wd_cnt;
        fwd      = 1'b0;
        inc_done = 1'b0;
        inc_drop = 1'b0;
        inc_to   = 1'b0;
        case (state)
            ST_RECOVER: begin
                if (rec_cnt == REC_LAST) begin
                    rec_d   = '0;
                    state_d = enable_in ? ST_ARM : ST_IDLE;
                end else begin
                    rec_d = rec_cnt + 1'b1;
                end
            end
            ST_IDLE: begin
                if (enable_in) state_d = ST_ARM;
            end
            ST_ARM: begin
                // Disable wins over a coincident SOF: nothing is admitted.
                if (!enable_in) begin
                    state_d = ST_IDLE;
                end else if (sof) begin
                    fwd     = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Abort takes priority; the pixel of the abort cycle is not sent.
                if (!enable_in) begin
                    inc_drop = 1'b1;
                    state_d  = ST_IDLE;
                end else if (pixel_valid_in) begin
                    fwd = 1'b1;
                    if (eof) begin
                        wd_d    = WD_RELOAD;
                        state_d = ST_PROCESS;
                    end else if (sof) begin
                        // Restarted frame: the partial one is lost, the new one loads.
                        inc_drop = 1'b1;
                    end
                end
            end
            ST_PROCESS: begin
                inc_drop = sof;
                if (wd_cnt != '0) wd_d = wd_cnt - 1'b1;
                if (skel_last) begin
                    inc_done = 1'b1;
                    state_d  = enable_in ? ST_ARM : ST_IDLE;
                end else if (wd_cnt == '0) begin
                    inc_to  = 1'b1;
                    rec_d   = '0;
                    state_d = ST_RECOVER;
                end
            end
            default: begin
                rec_d   = '0;
                state_d = ST_RECOVER;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state           <= ST_RECOVER;
            rec_cnt         <= '0;
            wd_cnt          <= '0;
            skel_valid_out  <= 1'b0;
            skel_hcount_out <= '0;
            skel_vcount_out <= '0;
            skel_pixel_out  <= 1'b0;
            frame_done_out  <= 1'b0;
        end else begin
            state          <= state_d;
            rec_cnt        <= rec_d;
            wd_cnt         <= wd_d;
            skel_valid_out <= fwd;
            frame_done_out <= inc_done;
            if (fwd) begin
                skel_hcount_out <= hcount_in;
                skel_vcount_out <= vcount_in;
                skel_pixel_out  <= pixel_in;
            end
        end
    end

    assign skel_rst_out = (state == ST_RECOVER);
    assign state_out    = state;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_done_cnt (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .inc_in    (inc_done),
        .count_out (frames_done_out)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_drop_cnt (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .inc_in    (inc_drop),
        .count_out (frames_dropped_out)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_timeout_cnt (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .inc_in    (inc_to),
        .count_out (timeouts_out)
    );

endmodule

// File: tb/tb_skeleton_frame_scheduler.sv
// Directed bench for skeleton_frame_scheduler. A second instance with 2-bit
// counters shares all inputs and shows counter saturation.
module tb_skeleton_frame_scheduler;

    localparam int H  = 320;
    localparam int V  = 180;
    localparam int HW = 9;
    localparam int VW = 8;
    localparam int T  = 100;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          enable_in;
    logic [HW-1:0] hcount_in;
    logic [VW-1:0] vcount_in;
    logic          pixel_in;
    logic          pixel_valid_in;
    logic          skel_valid_in;
    logic [HW-1:0] skel_hcount_in;
    logic [VW-1:0] skel_vcount_in;

    logic [HW-1:0] skel_hcount_out;
    logic [VW-1:0] skel_vcount_out;
    logic          skel_pixel_out, skel_valid_out, skel_rst_out, frame_done_out;
    logic [15:0]   frames_done_out, frames_dropped_out, timeouts_out;
    logic [2:0]    state_out;

    logic [HW-1:0] s_hcount;
    logic [VW-1:0] s_vcount;
    logic          s_pixel, s_valid, s_rst, s_done;
    logic [1:0]    s_fd, s_drop, s_to;
    logic [2:0]    s_state;

    always #5 clk_in = ~clk_in;

    skeleton_frame_scheduler #(
        .HORIZONTAL_COUNT(H), .VERTICAL_COUNT(V), .TIMEOUT_CYCLES(T), .CNT_WIDTH(16)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in),
        .hcount_in(hcount_in), .vcount_in(vcount_in), .pixel_in(pixel_in),
        .pixel_valid_in(pixel_valid_in), .skel_valid_in(skel_valid_in),
        .skel_hcount_in(skel_hcount_in), .skel_vcount_in(skel_vcount_in),
        .skel_hcount_out(skel_hcount_out), .skel_vcount_out(skel_vcount_out),
        .skel_pixel_out(skel_pixel_out), .skel_valid_out(skel_valid_out),
        .skel_rst_out(skel_rst_out), .frame_done_out(frame_done_out),
        .frames_done_out(frames_done_out), .frames_dropped_out(frames_dropped_out),
        .timeouts_out(timeouts_out), .state_out(state_out)
    );

    skeleton_frame_scheduler #(
        .HORIZONTAL_COUNT(H), .VERTICAL_COUNT(V), .TIMEOUT_CYCLES(T), .CNT_WIDTH(2)
    ) dut_sat (
        .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in),
        .hcount_in(hcount_in), .vcount_in(vcount_in), .pixel_in(pixel_in),
        .pixel_valid_in(pixel_valid_in), .skel_valid_in(skel_valid_in),
        .skel_hcount_in(skel_hcount_in), .skel_vcount_in(skel_vcount_in),
        .skel_hcount_out(s_hcount), .skel_vcount_out(s_vcount),
        .skel_pixel_out(s_pixel), .skel_valid_out(s_valid),
        .skel_rst_out(s_rst), .frame_done_out(s_done),
        .frames_done_out(s_fd), .frames_dropped_out(s_drop),
        .timeouts_out(s_to), .state_out(s_state)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic          en, pv;
        logic [HW-1:0] h;
        logic [VW-1:0] v;
        logic          px, sv;
        logic [HW-1:0] sh;
        logic [VW-1:0] svv;
        logic [2:0]    e_state;
        logic          e_valid, e_done;
        int            e_fd, e_drop;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic en, pv, input int h, v, input logic px, sv,
                                input int sh, svv, input int st, input logic vld, dn,
                                input int fd, drop);
        vec_t r;
        r.en = en; r.pv = pv; r.h = HW'(h); r.v = VW'(v); r.px = px; r.sv = sv;
        r.sh = HW'(sh); r.svv = VW'(svv); r.e_state = 3'(st); r.e_valid = vld;
        r.e_done = dn; r.e_fd = fd; r.e_drop = drop;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic en, pv, input logic [HW-1:0] h, input logic [VW-1:0] v,
                         input logic px, sv, input logic [HW-1:0] sh, input logic [VW-1:0] svv);
        enable_in      = en;
        pixel_valid_in = pv;
        hcount_in      = h;
        vcount_in      = v;
        pixel_in       = px;
        skel_valid_in  = sv;
        skel_hcount_in = sh;
        skel_vcount_in = svv;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    // Counts cycles with skel_rst_out high, starting from the current sample.
    task automatic count_recover(input string name);
        int n = 0;
        while (skel_rst_out && n < 20) begin
            n++;
            tick();
        end
        check({name, "_rst_cycles"}, n, 4);
        check({name, "_state_after"}, state_out, 2);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int mism;
        logic [HW-1:0] hh;
        logic [VW-1:0] vv;
        logic px;

        rst_in = 1'b1;
        idle();
        repeat (2) tick();
        check("rst_state", state_out, 0);
        check("rst_skel_rst", skel_rst_out, 1);
        check("rst_valid", skel_valid_out, 0);
        check("rst_done", frame_done_out, 0);
        check("rst_counters", {frames_done_out, frames_dropped_out}, 0);
        check("rst_timeouts", timeouts_out, 0);
        rst_in = 1'b0;
        count_recover("release");

        // full frame
        mism = 0;
        for (int v = 0; v < V; v++) begin
            for (int h = 0; h < H; h++) begin
                hh = HW'(h);
                vv = VW'(v);
                px = hh[0] ^ vv[1] ^ hh[3];
                drive(1'b1, 1'b1, hh, vv, px, 1'b0, '0, '0);
                tick();
                if (!(skel_valid_out === 1'b1 && skel_hcount_out === hh &&
                      skel_vcount_out === vv && skel_pixel_out === px))
                    mism++;
                if (h == 0 && v == 0) check("full_state_after_sof", state_out, 3);
            end
        end
        check("full_frame_mismatches", mism, 0);
        check("full_state_after_eof", state_out, 4);

        vecs.push_back(mk(1,1,  0,  0,1, 0,  0,  0, 4,0,0,0,1));
        vecs.push_back(mk(1,1,  5,  0,0, 0,  0,  0, 4,0,0,0,1));
        vecs.push_back(mk(1,0,  0,  0,0, 1, 10, 10, 4,0,0,0,1));
        vecs.push_back(mk(1,0,  0,  0,0, 1,319,179, 2,0,1,1,1));
        vecs.push_back(mk(1,0,  0,  0,0, 0,  0,  0, 2,0,0,1,1));
        vecs.push_back(mk(1,1,  3,  0,1, 0,  0,  0, 2,0,0,1,1));
        vecs.push_back(mk(1,0,  0,  0,0, 1,319,179, 2,0,0,1,1));
        vecs.push_back(mk(1,1,  0,  0,1, 0,  0,  0, 3,1,0,1,1));
        vecs.push_back(mk(1,1,  1,  0,0, 0,  0,  0, 3,1,0,1,1));
        vecs.push_back(mk(1,0,  7,  7,1, 0,  0,  0, 3,0,0,1,1));
        vecs.push_back(mk(1,1,  0,  0,0, 0,  0,  0, 3,1,0,1,2));
        vecs.push_back(mk(1,1,400,200,1, 0,  0,  0, 3,1,0,1,2));
        vecs.push_back(mk(1,1,319,179,1, 0,  0,  0, 4,1,0,1,2));
        vecs.push_back(mk(0,0,  0,  0,0, 1,319,179, 1,0,1,2,2));
        vecs.push_back(mk(0,1,  0,  0,1, 0,  0,  0, 1,0,0,2,2));
        vecs.push_back(mk(1,0,  0,  0,0, 0,  0,  0, 2,0,0,2,2));
        vecs.push_back(mk(0,1,  0,  0,1, 0,  0,  0, 1,0,0,2,2));
        vecs.push_back(mk(1,0,  0,  0,0, 0,  0,  0, 2,0,0,2,2));
        vecs.push_back(mk(1,1,  0,  0,1, 0,  0,  0, 3,1,0,2,2));
        vecs.push_back(mk(0,1,  1,  0,1, 0,  0,  0, 1,0,0,2,3));
        vecs.push_back(mk(1,1,  2,  0,1, 0,  0,  0, 2,0,0,2,3));
        vecs.push_back(mk(1,1,  0,  0,0, 0,  0,  0, 3,1,0,2,3));
        vecs.push_back(mk(1,1,319,179,0, 0,  0,  0, 4,1,0,2,3));

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].pv, vecs[i].h, vecs[i].v, vecs[i].px,
                  vecs[i].sv, vecs[i].sh, vecs[i].svv);
            tick();
            check($sformatf("vec%0d_state", i), state_out, vecs[i].e_state);
            check($sformatf("vec%0d_valid", i), skel_valid_out, vecs[i].e_valid);
            check($sformatf("vec%0d_done", i), frame_done_out, vecs[i].e_done);
            check($sformatf("vec%0d_frames_done", i), frames_done_out, vecs[i].e_fd);
            check($sformatf("vec%0d_dropped", i), frames_dropped_out, vecs[i].e_drop);
            check($sformatf("vec%0d_timeouts", i), timeouts_out, 0);
            if (vecs[i].e_valid)
                check($sformatf("vec%0d_fwd_data", i),
                      {skel_hcount_out, skel_vcount_out, skel_pixel_out},
                      {vecs[i].h, vecs[i].v, vecs[i].px});
        end

        // completion and watchdog expiry in the same cycle: completion wins
        idle();
        repeat (T - 1) tick();
        check("tie_pre_state", state_out, 4);
        drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b1, HW'(H-1), VW'(V-1));
        tick();
        check("tie_state", state_out, 2);
        check("tie_done_pulse", frame_done_out, 1);
        check("tie_frames_done", frames_done_out, 3);
        check("tie_timeouts", timeouts_out, 0);
        idle();
        tick();
        check("tie_done_cleared", frame_done_out, 0);

        // watchdog expiry
        drive(1'b1, 1'b1, '0, '0, 1'b1, 1'b0, '0, '0);
        tick();
        drive(1'b1, 1'b1, HW'(H-1), VW'(V-1), 1'b1, 1'b0, '0, '0);
        tick();
        check("wd_enter_process", state_out, 4);
        idle();
        repeat (T - 1) tick();
        check("wd_cycle100_state", state_out, 4);
        check("wd_cycle100_timeouts", timeouts_out, 0);
        tick();
        check("wd_recover_state", state_out, 0);
        check("wd_timeouts", timeouts_out, 1);
        check("wd_skel_rst", skel_rst_out, 1);
        count_recover("wd");

        // one more frame with a dropped SOF to saturate the 2-bit instance
        drive(1'b1, 1'b1, '0, '0, 1'b0, 1'b0, '0, '0);
        tick();
        drive(1'b1, 1'b1, HW'(H-1), VW'(V-1), 1'b0, 1'b0, '0, '0);
        tick();
        drive(1'b1, 1'b1, '0, '0, 1'b0, 1'b0, '0, '0);
        tick();
        drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b1, HW'(H-1), VW'(V-1));
        tick();
        idle();
        check("final_frames_done", frames_done_out, 4);
        check("final_dropped", frames_dropped_out, 4);
        check("final_timeouts", timeouts_out, 1);
        check("sat_frames_done", s_fd, 3);
        check("sat_dropped", s_drop, 3);
        check("sat_timeouts", s_to, 1);

        // asynchronous reset in the middle of LOAD
        drive(1'b1, 1'b1, '0, '0, 1'b1, 1'b0, '0, '0);
        tick();
        check("midload_state", state_out, 3);
        drive(1'b1, 1'b1, 9'd1, '0, 1'b1, 1'b0, '0, '0);
        #3 rst_in = 1'b1;
        #1;
        check("async_state", state_out, 0);
        check("async_skel_rst", skel_rst_out, 1);
        check("async_valid", skel_valid_out, 0);
        check("async_counters", {frames_done_out, frames_dropped_out, timeouts_out}, 0);
        check("async_sat_counters", {s_fd, s_drop, s_to}, 0);
        tick();
        rst_in = 1'b0;
        idle();
        count_recover("rerelease");
        check("rerelease_counters", {frames_done_out, frames_dropped_out, timeouts_out}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/skeleton_frame_scheduler.md
# skeleton_frame_scheduler

Sequences whole frames from the thresholded camera stream into the skeletonizer. Admits exactly one complete frame at a time, drops frames arriving while a skeleton is in progress, and detects completion from the skeletonizer output stream. Runs a watchdog that resets a hung skeletonizer, and exposes saturating frame/drop/timeout counters for the debug HUD. Sits between the mask/threshold stage and the skeletonizer input.

## Interface
Parameters:
- HORIZONTAL_COUNT, 320, frame width in pixels
- VERTICAL_COUNT, 180, frame height in pixels
- TIMEOUT_CYCLES, 2_000_000, max cycles allowed in PROCESS
- CNT_WIDTH, 16, width of each statistics counter

Ports (HWIDTH = $clog2(HORIZONTAL_COUNT), VWIDTH = $clog2(VERTICAL_COUNT)):
- clk_in  input  1  single system clock
- rst_in  input  1  reset, asynchronous, active-high
- enable_in  input  1  admit new frames when high
- hcount_in  input  HWIDTH  camera pixel column
- vcount_in  input  VWIDTH  camera pixel row
- pixel_in  input  1  binary mask pixel
- pixel_valid_in  input  1  camera pixel strobe
- skel_valid_in  input  1  skeletonizer pixel_valid_out
- skel_hcount_in  input  HWIDTH  skeletonizer hcount_out
- skel_vcount_in  input  VWIDTH  skeletonizer vcount_out
- skel_hcount_out  output  HWIDTH  forwarded column to skeletonizer
- skel_vcount_out  output  VWIDTH  forwarded row
- skel_pixel_out  output  1  forwarded pixel
- skel_valid_out  output  1  forwarded strobe
- skel_rst_out  output  1  synchronous reset to skeletonizer
- frame_done_out  output  1  one-cycle pulse per completed skeleton
- frames_done_out  output  CNT_WIDTH  completed skeletons, saturating
- frames_dropped_out  output  CNT_WIDTH  dropped/aborted frames, saturating
- timeouts_out  output  CNT_WIDTH  watchdog firings, saturating
- state_out  output  3  current state encoding

## Operation
- SOF = pixel_valid_in with hcount_in==0 and vcount_in==0; EOF = pixel_valid_in at (H-1, V-1); SKEL_LAST = skel_valid_in at (H-1, V-1).
- States: RECOVER(0), IDLE(1), ARM(2), LOAD(3), PROCESS(4).
- RECOVER: skel_rst_out=1 for RECOVER_CYCLES (4) cycles, then to ARM if enable_in, else IDLE.
- IDLE: no forwarding; to ARM when enable_in.
- ARM: on SOF forward that pixel, go to LOAD; if enable_in low, go to IDLE.
- LOAD: forward every valid pixel. EOF: forward, go to PROCESS, clear watchdog. SOF (truncated frame): frames_dropped+1, forward SOF, stay in LOAD. enable_in low: frames_dropped+1, go to IDLE; no further pixels forwarded.
- PROCESS: nothing forwarded; each SOF increments frames_dropped. SKEL_LAST: frame_done pulse, frames_done+1, go to ARM (IDLE if enable_in low). Watchdog reaching TIMEOUT_CYCLES-1: timeouts+1, go to RECOVER. SKEL_LAST and timeout in the same cycle: completion wins.
- Simultaneous counter increments in one cycle are independent. All counters saturate at all-ones.
- Out-of-range hcount_in/vcount_in are forwarded unchanged in LOAD; the scheduler performs no validation.

## Timing
- Asynchronous reset: state=RECOVER with recovery counter 0, skel_rst_out=1, all other outputs 0, counters 0. After release, exactly 4 cycles of skel_rst_out, then ARM or IDLE.
- Forward path registered: pixel at cycle N appears on skel_* outputs at N+1; skel_valid_out is 0 in every non-forwarding cycle.
- State, counters and frame_done_out are registered, so updates are visible the cycle after the triggering input.
- Watchdog counts PROCESS cycles from 0. Timeout occurs on the TIMEOUT_CYCLES-th PROCESS cycle; the RECOVER state is visible the next cycle.
- Reset mid-frame: immediate abort, no counter increments, re-enter RECOVER.

## Structure
- Package skel_sched_pkg: state enum sched_state_t (encodings above), RECOVER_CYCLES=4.
- Sub-module sat_counter #(WIDTH): enable plus async reset; instantiated three times.
- Single FSM always_ff with an async reset sensitivity list; forward-path registers in the same process.

## Test plan
- Reset release, enable_in=1 -> skel_rst_out high 4 cycles, state_out 0→2, all counters 0.
- Full 320×180 frame in ARM -> all 57,600 pixels forwarded 1 cycle late; state 3 after SOF, 4 after EOF.
- Second frame during PROCESS, then SKEL_LAST -> frames_dropped=1, frame_done pulse 1 cycle, frames_done=1, state 2.
- TIMEOUT_CYCLES=100 with no SKEL_LAST -> timeouts=1 at PROCESS cycle 100, then 4 cycles of skel_rst_out, state 2.
- SOF at cycle 10 in LOAD, then enable_in low -> frames_dropped=2, state 1, skel_valid_out 0 afterward.
- Force frames_done to 16'hFFFF, complete one more frame -> stays 16'hFFFF; assert rst_in mid-LOAD -> counters 0 asynchronously.
